// File: rtl/sprite_plotter.sv
// sprite_plotter: sweeps a SPRITE_W x SPRITE_H sprite onto a VGA adapter's
// pixel-write port, one pixel per cycle, with clipping at the screen edge.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only while idle)
//   cmd_op                     00 draw, 01 erase, 10 fill, 11 no-op
//   cmd_x, cmd_y               sprite top-left corner
//   cmd_color                  draw/fill colour
//   cmd_mask                   bitmap, bit (row*SPRITE_W+col) set = pixel present
//   vga_x, vga_y, vga_colour   pixel address/colour to the adapter
//   vga_plot                   adapter write enable
//   busy                       command in progress (inverse of cmd_ready)
//   done                       one-cycle completion pulse
module sprite_plotter #(
   parameter int unsigned SPRITE_W    = 5,
   parameter int unsigned SPRITE_H    = 5,
   parameter int unsigned X_W         = 8,
   parameter int unsigned Y_W         = 7,
   parameter int unsigned COLOR_W     = 3,
   parameter int unsigned SCREEN_W    = 160,
   parameter int unsigned SCREEN_H    = 120,
   parameter int unsigned ERASE_COLOR = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [X_W-1:0]               cmd_x,
   input  logic [Y_W-1:0]               cmd_y,
   input  logic [COLOR_W-1:0]           cmd_color,
   input  logic [SPRITE_W*SPRITE_H-1:0] cmd_mask,
   output logic [X_W-1:0]               vga_x,
   output logic [Y_W-1:0]               vga_y,
   output logic [COLOR_W-1:0]           vga_colour,
   output logic                         vga_plot,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned MASK_W  = SPRITE_W * SPRITE_H;
   localparam int unsigned COL_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int unsigned ROW_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int unsigned IDX_W   = (MASK_W > 1) ? $clog2(MASK_W) : 1;
   localparam int unsigned XSUM_W  = X_W + 1;
   localparam int unsigned YSUM_W  = Y_W + 1;

   localparam logic [1:0] OP_DRAW  = 2'b00;
   localparam logic [1:0] OP_ERASE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [1:0]           op_q, op_d;
   logic [X_W-1:0]       x_q, x_d;
   logic [Y_W-1:0]       y_q, y_d;
   logic [COLOR_W-1:0]   color_q, color_d;
   logic [MASK_W-1:0]    mask_q, mask_d;

   logic [X_W-1:0]       vga_x_q, vga_x_d;
   logic [Y_W-1:0]       vga_y_q, vga_y_d;
   logic [COLOR_W-1:0]   vga_colour_q, vga_colour_d;
   logic                 vga_plot_q, vga_plot_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [XSUM_W-1:0]    x_sum;
   logic [YSUM_W-1:0]    y_sum;
   logic [IDX_W-1:0]     pix_idx;
   logic                 present;
   logic                 in_view;

   // State, counters, latched command and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         op_q         <= '0;
         x_q          <= '0;
         y_q          <= '0;
         color_q      <= '0;
         mask_q       <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         op_q         <= op_d;
         x_q          <= x_d;
         y_q          <= y_d;
         color_q      <= color_d;
         mask_q       <= mask_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next state, and the pixel that the next cycle will present.
   // Outputs are staged from the *_d values so pixel k appears in the
   // cycle right after the edge that selects it.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      op_d         = op_q;
      x_d          = x_q;
      y_d          = y_q;
      color_d      = color_q;
      mask_d       = mask_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               x_d     = cmd_x;
               y_d     = cmd_y;
               color_d = cmd_color;
               mask_d  = cmd_mask;
               col_d   = '0;
               row_d   = '0;
               state_d = (cmd_op == OP_NOP) ? DONE : SWEEP;
            end
         end
         SWEEP: begin
            if (col_q == COL_W'(SPRITE_W - 1)) begin
               col_d = '0;
               if (row_q == ROW_W'(SPRITE_H - 1)) begin
                  state_d = DONE;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Sums keep the carry bit so off-screen pixels never wrap into view
      x_sum   = {1'b0, x_d} + XSUM_W'(col_d);
      y_sum   = {1'b0, y_d} + YSUM_W'(row_d);
      pix_idx = IDX_W'(row_d) * IDX_W'(SPRITE_W) + IDX_W'(col_d);
      present = (op_d == OP_FILL) || mask_d[pix_idx];
      in_view = (32'(x_sum) < SCREEN_W) && (32'(y_sum) < SCREEN_H);

      if (state_d == SWEEP) begin
         vga_x_d      = x_sum[X_W-1:0];
         vga_y_d      = y_sum[Y_W-1:0];
         vga_colour_d = (op_d == OP_ERASE) ? COLOR_W'(ERASE_COLOR) : color_d;
         vga_plot_d   = present && in_view;
      end

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   assign cmd_ready  = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;

   // OP_DRAW is the default path (mask-gated, latched colour)
   logic unused_op_draw;
   assign unused_op_draw = ^OP_DRAW;

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: the driver pushes the expected pixel
// writes and done pulse (with their cycle numbers) from a plain arithmetic
// model; a negedge monitor checks every cycle against the queues.
module tb_sprite_plotter;

   localparam int SW = 5;
   localparam int SH = 5;
   localparam int N  = SW * SH;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_x;
   logic [6:0]  cmd_y;
   logic [2:0]  cmd_color;
   logic [24:0] cmd_mask;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        busy;
   logic        done;

   sprite_plotter dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .cmd_color  (cmd_color),
      .cmd_mask   (cmd_mask),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int x;
      int y;
      int c;
   } pix_t;

   pix_t exp_q[$];
   int   done_q[$];
   int   cyc = 0;
   int   ready_from = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input bit ok, input string name, input int act, input int req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, req);
      end
   endfunction

   // Monitor: compares every cycle against what the model scheduled
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         done_q.delete();
      end else begin
         bit   exp_plot;
         bit   exp_done;
         bit   exp_ready;
         pix_t p;
         exp_ready = (cyc >= ready_from);
         chk(cmd_ready == exp_ready, "cmd_ready", int'(cmd_ready), int'(exp_ready));
         chk(busy == !exp_ready, "busy", int'(busy), int'(!exp_ready));
         exp_plot = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         chk(vga_plot == exp_plot, "vga_plot", int'(vga_plot), int'(exp_plot));
         if (exp_plot) begin
            p = exp_q.pop_front();
            if (vga_plot) begin
               chk(int'(vga_x) == p.x, "vga_x", int'(vga_x), p.x);
               chk(int'(vga_y) == p.y, "vga_y", int'(vga_y), p.y);
               chk(int'(vga_colour) == p.c, "vga_colour", int'(vga_colour), p.c);
            end
         end
         exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
         chk(done == exp_done, "done", int'(done), int'(exp_done));
         if (exp_done) void'(done_q.pop_front());
      end
   end

   // Reference model: which pixels a command writes and when
   task automatic model(input int a, input int op, input int x, input int y,
                        input int c, input logic [24:0] m);
      pix_t p;
      for (int k = 0; k < N; k++) begin
         int px, py;
         bit pres;
         px   = x + (k % SW);
         py   = y + (k / SW);
         pres = (op == 2) ? 1'b1 : m[k];
         if (op != 3 && pres && px < 160 && py < 120) begin
            p.cyc = a + k;
            p.x   = px;
            p.y   = py;
            p.c   = (op == 1) ? 0 : c;
            exp_q.push_back(p);
         end
      end
      if (op == 3) begin
         done_q.push_back(a);
         ready_from = a + 1;
      end else begin
         done_q.push_back(a + N);
         ready_from = a + N + 1;
      end
   endtask

   // Present a command (valid stays high afterwards) and record its acceptance
   task automatic send(input logic [1:0] op, input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, input logic [24:0] m, output int a);
      int n;
      @(negedge clk);
      cmd_op    = op;
      cmd_x     = x;
      cmd_y     = y;
      cmd_color = c;
      cmd_mask  = m;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk(cmd_ready == 1'b1, "ready_timeout", int'(cmd_ready), 1);
         $display("test done: total=%0d bad=%0d", total, bad);
         $fatal(1, "engine never became ready");
      end
      @(posedge clk);
      #1;
      a = cyc;
      model(a, int'(op), int'(x), int'(y), int'(c), m);
   endtask

   initial begin
      int a;
      int n;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_x     = '0;
      cmd_y     = '0;
      cmd_color = '0;
      cmd_mask  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(vga_plot == 1'b0, "rst_plot", int'(vga_plot), 0);
      chk(cmd_ready == 1'b1, "rst_ready", int'(cmd_ready), 1);
      chk(busy == 1'b0, "rst_busy", int'(busy), 0);
      chk(done == 1'b0, "rst_done", int'(done), 0);
      chk(vga_x == 8'd0, "rst_x", int'(vga_x), 0);
      chk(vga_y == 7'd0, "rst_y", int'(vga_y), 0);
      chk(vga_colour == 3'd0, "rst_colour", int'(vga_colour), 0);
      #1 reset = 1'b0;

      // Reset during the sweep, at pixel 7
      send(2'b00, 8'd30, 7'd40, 3'd5, 25'h1ff_ffff, a);
      while (cyc < a + 7) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk(vga_plot == 1'b0, "midrst_plot", int'(vga_plot), 0);
      chk(done == 1'b0, "midrst_done", int'(done), 0);
      chk(cmd_ready == 1'b1, "midrst_ready", int'(cmd_ready), 1);
      cmd_valid = 1'b0;
      exp_q.delete();
      done_q.delete();
      ready_from = 0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);

      // Full draw, sparse erase, clipped fills, no-op (valid held high)
      send(2'b00, 8'd10,  7'd20,  3'b100, 25'h1ff_ffff, a);
      send(2'b01, 8'd0,   7'd0,   3'd6,   25'h100_1001, a);
      send(2'b10, 8'd157, 7'd117, 3'd7,   25'h000_0000, a);
      send(2'b10, 8'd255, 7'd10,  3'd2,   25'h1ff_ffff, a);
      send(2'b11, 8'd5,   7'd5,   3'd1,   25'h1ff_ffff, a);
      send(2'b00, 8'd100, 7'd127, 3'd3,   25'h1ff_ffff, a);

      // Random commands, mostly back-to-back, some near the screen edges
      for (int i = 0; i < 30; i++) begin
         logic [7:0] rx;
         logic [6:0] ry;
         rx = 8'($urandom_range(0, 255));
         ry = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 2) == 0) rx = 8'($urandom_range(150, 165));
         if ($urandom_range(0, 2) == 0) ry = 7'($urandom_range(110, 125));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
         send(2'($urandom_range(0, 3)), rx, ry, 3'($urandom), 25'($urandom), a);
      end

      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (cyc <= ready_from + 2 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      #1;
      chk(exp_q.size() == 0, "plots_left", exp_q.size(), 0);
      chk(done_q.size() == 0, "dones_left", done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Responder-side drawing engine for the game controller's draw and erase requests.
- Accepts one command per handshake: op, base coordinate, colour, bitmap mask.
- Sweeps the SPRITE_W x SPRITE_H sprite pixel by pixel onto the VGA adapter's x/y/colour/plot inputs, with screen-edge clipping.
- Returns a single-cycle done pulse so the controller needs no internal pixel counters.

Parameters:
SPRITE_W, 5, sprite width in pixels (>=1)
SPRITE_H, 5, sprite height in pixels (>=1)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOR_W, 3, colour width
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
ERASE_COLOR, 0, colour driven for erase ops

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle, can accept a command
cmd_op  in  2  00 draw, 01 erase, 10 fill (ignore mask), 11 no-op
cmd_x  in  X_W  sprite top-left x
cmd_y  in  Y_W  sprite top-left y
cmd_color  in  COLOR_W  draw/fill colour
cmd_mask  in  SPRITE_W*SPRITE_H  bitmap; bit (row*SPRITE_W+col) = 1 means pixel present
vga_x  out  X_W  pixel x to VGA adapter
vga_y  out  Y_W  pixel y to VGA adapter
vga_colour  out  COLOR_W  pixel colour
vga_plot  out  1  write enable to VGA adapter
busy  out  1  command in progress (= !cmd_ready)
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE; cmd_ready=1; busy=0; done=0; vga_plot=0; vga_x/vga_y/vga_colour=0; col/row counters and latched command cleared.
- A reset in mid-sweep aborts the sweep: no further plots and no done pulse.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1 at a clock edge, latch op/x/y/color/mask and clear col=row=0.
  - Next state is SWEEP for op 00/01/10, or DONE for op 11.
- SWEEP:
  - cmd_ready=0; cmd_valid is ignored.
  - Each cycle presents the pixel at (row,col), derived only from registers, with no combinational path from cmd_* inputs.
  - vga_x = low X_W bits of (base_x + col), sum computed at X_W+1 bits.
  - vga_y = low Y_W bits of (base_y + row), sum computed at Y_W+1 bits.
  - vga_colour = ERASE_COLOR for erase, latched color otherwise.
  - vga_plot = present AND (full x sum < SCREEN_W) AND (full y sum < SCREEN_H).
  - present = mask bit for draw/erase; present = 1 for fill.
  - Order is row-major with col fastest: col increments each cycle; at col=SPRITE_W-1, col wraps to 0 and row increments.
  - At (SPRITE_W-1, SPRITE_H-1), next state is DONE.
- DONE: done=1 for exactly one cycle; vga_plot=0; cmd_ready=0; next state IDLE.
- Outside SWEEP: vga_plot=0. vga_x/vga_y/vga_colour hold their last values and are don't-care.
- Timing for a command accepted at edge E0:
  - Pixel k (0..N-1, N=SPRITE_W*SPRITE_H) is presented in the cycle after edge E0+k.
  - done is high in the cycle after edge E0+N.
  - cmd_ready returns high after edge E0+N+1.
  - Total occupancy is N+2 cycles.
- No-op: done is high in the cycle after E0; no plots.
- A command can be accepted in the first IDLE cycle after DONE, so back-to-back commands have no extra gap.
- Clipped pixels still consume their cycle, so sweep length is independent of position and mask.
- Mask and coordinates are sampled only at acceptance; later input changes have no effect.

Test Plan:
1. Reset mid-sweep: reset asserted at pixel 7 -> vga_plot=0 immediately; no done; cmd_ready=1 after release; the next command sweeps from pixel 0.
2. Draw: x=10, y=20, color=3'b100, mask all ones -> exactly 25 plot cycles in row-major order (10,20),(11,20)...(14,24), all colour 4; done high one cycle after the last pixel; cmd_ready high one cycle after done.
3. Erase with a sparse mask (only bits 0, 12, 24 set) at x=0, y=0 -> plot only at (0,0), (2,2), (4,4) with colour 0; 25 sweep cycles total; one done pulse.
4. Clipping: fill at x=157, y=117, colour 7 -> plots only at x 157..159 and y 117..119, 9 pixels; the remaining 16 cycles have plot=0; done is still N+1 cycles after acceptance. Also x=255 -> no plots; no wrap to x=0..3.
5. Handshake: cmd_valid held high throughout -> second command accepted in the cycle after done; inputs changed mid-sweep do not alter output pixels. Op 11 -> done in the cycle after acceptance with zero plots.
